regfile_wb_scoreboard: RTL and testbench

Write-back scheduler and scoreboard for the 32-entry integer register file. It merges two write-back requesters onto the single register file write port: the in-order pipeline (A) and the long-latency multiply/divide unit (B). It tracks destination registers owned by in-flight long-latency operations and raises a decode stall on RAW/WAW hazards against them. It sits between execute/write-back and the register file write port, beside decode.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_wb_scoreboard_if.sv | 49 ++++
 rtl/wb_arbiter.sv | 46 ++++
 rtl/regfile_wb_scoreboard.sv | 95 +++++++++
 tb/tb_regfile_wb_scoreboard.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file package.
// Holds the register file geometry, the write-port record type and the stack pointer
// constants used elsewhere in the core.
package regfile_pkg;

  localparam int unsigned REGISTER_WIDTH = 32;
  localparam int unsigned REGISTER_DEPTH = 32;
  localparam int unsigned AW             = $clog2(REGISTER_DEPTH);

  // Not used by the write-back scoreboard; kept here for the rest of the core.
  localparam int unsigned STACK_POINTER_ADD = 2;
  localparam int unsigned STACK_POINTER_VAL = 1024;

  typedef logic [AW-1:0]             reg_addr_t;
  typedef logic [REGISTER_WIDTH-1:0] reg_data_t;

  // One register file write-port transfer.
  typedef struct packed {
    logic      we;
    reg_addr_t addr;
    reg_data_t data;
  } wb_port_t;

endpackage

// File: rtl/regfile_wb_scoreboard_if.sv
// Bundle of the write-back scheduler signals.
// master : drives requests, issue info and source addresses (pipeline / test side).
// slave  : the scheduler; returns READY, STALL, the register file write port and BUSY_COUNT.
interface regfile_wb_scoreboard_if;
  import regfile_pkg::*;

  // Pipeline write-back request (A).
  logic      A_VALID;
  reg_addr_t A_ADDRESS;
  reg_data_t A_DATA;
  logic      A_READY;

  // Long-latency unit write-back request (B).
  logic      B_VALID;
  reg_addr_t B_ADDRESS;
  reg_data_t B_DATA;
  logic      B_READY;

  // Decode side.
  logic      ISSUE_VALID;
  reg_addr_t ISSUE_RD;
  logic      ISSUE_LONG;
  reg_addr_t RS1_ADDRESS;
  reg_addr_t RS2_ADDRESS;
  logic      STALL;

  // Register file write port and scoreboard occupancy.
  reg_addr_t     RD_ADDRESS;
  reg_data_t     RD_DATA;
  logic          RD_WRITE_EN;
  logic [AW:0]   BUSY_COUNT;

  modport master (
    output A_VALID, A_ADDRESS, A_DATA,
    output B_VALID, B_ADDRESS, B_DATA,
    output ISSUE_VALID, ISSUE_RD, ISSUE_LONG, RS1_ADDRESS, RS2_ADDRESS,
    input  A_READY, B_READY, STALL,
    input  RD_ADDRESS, RD_DATA, RD_WRITE_EN, BUSY_COUNT
  );

  modport slave (
    input  A_VALID, A_ADDRESS, A_DATA,
    input  B_VALID, B_ADDRESS, B_DATA,
    input  ISSUE_VALID, ISSUE_RD, ISSUE_LONG, RS1_ADDRESS, RS2_ADDRESS,
    output A_READY, B_READY, STALL,
    output RD_ADDRESS, RD_DATA, RD_WRITE_EN, BUSY_COUNT
  );

endinterface

// File: rtl/wb_arbiter.sv
// Two-input write-back arbiter: A (pipeline) has fixed priority over B (long-latency unit),
// except that B is forced through once it has been refused STARVE_LIMIT cycles in a row.
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   a_valid, b_valid  request lines
//   a_grant, b_grant  combinational grants, mutually exclusive
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_grant,
  output logic b_grant
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  logic [3:0] sc_q, sc_d;
  logic       starved;

  assign starved = (sc_q == Limit);

  always_comb begin
    b_grant = b_valid & (starved | ~a_valid);
    a_grant = a_valid & ~b_grant;
  end

  // Counts consecutive refusals of B; any cycle without a waiting B restarts it.
  always_comb begin
    sc_d = '0;
    if (b_valid && !b_grant) begin
      sc_d = starved ? sc_q : sc_q + 4'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sc_q <= '0;
    end else begin
      sc_q <= sc_d;
    end
  end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Write-back scheduler and scoreboard for the integer register file.
// Merges the pipeline (A) and long-latency unit (B) write-backs onto the single write port,
// tracks registers owned by in-flight long-latency operations and stalls decode on RAW/WAW
// hazards against them.
// Ports:
//   CLK, RST  clock, asynchronous active-high reset
//   bus       slave side of regfile_wb_scoreboard_if (requests, issue, STALL, write port)
module regfile_wb_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  regfile_wb_scoreboard_if.slave    bus
);

  localparam int unsigned CW = AW + 1;

  logic                      a_grant, b_grant;
  logic                      stall;
  logic                      busy_set;
  logic [REGISTER_DEPTH-1:0] busy_q, busy_d;
  logic [CW-1:0]             busy_count_q, busy_count_d;
  wb_port_t                  wb_q, wb_d;

  wb_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_wb_arbiter (
    .CLK     (CLK),
    .RST     (RST),
    .a_valid (bus.A_VALID),
    .b_valid (bus.B_VALID),
    .a_grant (a_grant),
    .b_grant (b_grant)
  );

  assign bus.A_READY = a_grant;
  assign bus.B_READY = b_grant;

  // Sources read busy registers (RAW), or the destination is still owned (WAW).
  always_comb begin
    stall = busy_q[bus.RS1_ADDRESS] | busy_q[bus.RS2_ADDRESS] |
            (bus.ISSUE_VALID & busy_q[bus.ISSUE_RD]);
  end

  assign bus.STALL = stall;
  assign busy_set  = bus.ISSUE_VALID & bus.ISSUE_LONG & ~stall & (bus.ISSUE_RD != '0);

  // Clear before set so a same-index collision leaves the bit owned.
  always_comb begin
    busy_d = busy_q;
    if (b_grant) begin
      busy_d[bus.B_ADDRESS] = 1'b0;
    end
    if (busy_set) begin
      busy_d[bus.ISSUE_RD] = 1'b1;
    end
    busy_d[0] = 1'b0;
    busy_count_d = CW'($countones(busy_d));
  end

  // Address and data hold when idle; only the enable drops. x0 writes complete but never commit.
  always_comb begin
    wb_d    = wb_q;
    wb_d.we = 1'b0;
    if (a_grant) begin
      wb_d.we   = (bus.A_ADDRESS != '0);
      wb_d.addr = bus.A_ADDRESS;
      wb_d.data = bus.A_DATA;
    end else if (b_grant) begin
      wb_d.we   = (bus.B_ADDRESS != '0);
      wb_d.addr = bus.B_ADDRESS;
      wb_d.data = bus.B_DATA;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q       <= '0;
      busy_count_q <= '0;
      wb_q         <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
      wb_q         <= wb_d;
    end
  end

  assign bus.RD_WRITE_EN = wb_q.we;
  assign bus.RD_ADDRESS  = wb_q.addr;
  assign bus.RD_DATA     = wb_q.data;
  assign bus.BUSY_COUNT  = busy_count_q;

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
module tb_regfile_wb_scoreboard;
  import regfile_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  regfile_wb_scoreboard_if bus ();

  regfile_wb_scoreboard #(
    .STARVE_LIMIT (4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic      we;
    reg_addr_t addr;
    reg_data_t data;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_wb(input reg_addr_t addr, input reg_data_t data);
    exp_t e;
    e.we   = (addr != '0);
    e.addr = addr;
    e.data = data;
    q.push_back(e);
  endtask

  // Advance one clock; the write port then shows last cycle's handshake (or nothing).
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check_eq("wport_we", 64'(bus.RD_WRITE_EN), 64'(e.we));
      check_eq("wport_addr", 64'(bus.RD_ADDRESS), 64'(e.addr));
      check_eq("wport_data", 64'(bus.RD_DATA), 64'(e.data));
    end else begin
      check_eq("wport_idle_we", 64'(bus.RD_WRITE_EN), 64'd0);
    end
  endtask

  initial begin
    int ai;
    bus.A_VALID = 1'b0; bus.A_ADDRESS = '0; bus.A_DATA = '0;
    bus.B_VALID = 1'b0; bus.B_ADDRESS = '0; bus.B_DATA = '0;
    bus.ISSUE_VALID = 1'b0; bus.ISSUE_RD = '0; bus.ISSUE_LONG = 1'b0;
    bus.RS1_ADDRESS = '0; bus.RS2_ADDRESS = '0;

    // Reset with both requesters pending.
    bus.A_VALID = 1'b1; bus.A_ADDRESS = 5'd1; bus.A_DATA = 32'h1111_1111;
    bus.B_VALID = 1'b1; bus.B_ADDRESS = 5'd2; bus.B_DATA = 32'h2222_2222;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    check_eq("rst_we", 64'(bus.RD_WRITE_EN), 64'd0);
    check_eq("rst_addr", 64'(bus.RD_ADDRESS), 64'd0);
    check_eq("rst_data", 64'(bus.RD_DATA), 64'd0);
    check_eq("rst_count", 64'(bus.BUSY_COUNT), 64'd0);
    check_eq("rst_stall", 64'(bus.STALL), 64'd0);
    check_eq("first_a_ready", 64'(bus.A_READY), 64'd1);
    check_eq("first_b_ready", 64'(bus.B_READY), 64'd0);
    push_wb(5'd1, 32'h1111_1111);
    tick();
    bus.A_VALID = 1'b0;
    #1;
    check_eq("b_alone_ready", 64'(bus.B_READY), 64'd1);
    push_wb(5'd2, 32'h2222_2222);
    tick();
    bus.B_VALID = 1'b0;
    #1;
    check_eq("idle_a_ready", 64'(bus.A_READY), 64'd0);
    check_eq("idle_b_ready", 64'(bus.B_READY), 64'd0);
    tick();

    // Long op to x5, RAW on x5, then B retires it.
    bus.ISSUE_VALID = 1'b1; bus.ISSUE_RD = 5'd5; bus.ISSUE_LONG = 1'b1;
    #1;
    check_eq("issue5_stall", 64'(bus.STALL), 64'd0);
    tick();
    bus.ISSUE_VALID = 1'b0; bus.ISSUE_LONG = 1'b0;
    bus.RS1_ADDRESS = 5'd5;
    #1;
    check_eq("x5_count", 64'(bus.BUSY_COUNT), 64'd1);
    check_eq("x5_raw_stall", 64'(bus.STALL), 64'd1);
    bus.B_VALID = 1'b1; bus.B_ADDRESS = 5'd5; bus.B_DATA = 32'hDEAD_BEEF;
    #1;
    check_eq("x5_b_ready", 64'(bus.B_READY), 64'd1);
    push_wb(5'd5, 32'hDEAD_BEEF);
    tick();
    bus.B_VALID = 1'b0;
    #1;
    check_eq("x5_stall_drop", 64'(bus.STALL), 64'd0);
    check_eq("x5_count_drop", 64'(bus.BUSY_COUNT), 64'd0);
    bus.RS1_ADDRESS = '0;

    // Starvation: A held high, B raised at cycle 0, forced through in cycle 4.
    ai = 0;
    bus.A_VALID = 1'b1;
    bus.B_VALID = 1'b1; bus.B_ADDRESS = 5'd12; bus.B_DATA = 32'h0000_B0B0;
    for (int c = 0; c < 6; c++) begin
      bus.A_ADDRESS = 5'(10 + ai);
      bus.A_DATA    = 32'hA000 + 32'(ai);
      if (c == 5) bus.B_VALID = 1'b0;
      #1;
      check_eq($sformatf("starve_a_ready_c%0d", c), 64'(bus.A_READY), 64'(c != 4));
      check_eq($sformatf("starve_b_ready_c%0d", c), 64'(bus.B_READY), 64'(c == 4));
      if (c == 4) begin
        push_wb(5'd12, 32'h0000_B0B0);
      end else begin
        push_wb(5'(10 + ai), 32'hA000 + 32'(ai));
        ai++;
      end
      tick();
    end
    bus.A_VALID = 1'b0;

    // Writes and long issue to x0.
    bus.A_VALID = 1'b1; bus.A_ADDRESS = 5'd0; bus.A_DATA = 32'h0000_0055;
    #1;
    check_eq("x0_a_ready", 64'(bus.A_READY), 64'd1);
    push_wb(5'd0, 32'h0000_0055);
    tick();
    bus.A_VALID = 1'b0;
    bus.ISSUE_VALID = 1'b1; bus.ISSUE_RD = 5'd0; bus.ISSUE_LONG = 1'b1;
    #1;
    check_eq("x0_issue_stall", 64'(bus.STALL), 64'd0);
    tick();
    bus.ISSUE_VALID = 1'b0;
    #1;
    check_eq("x0_count", 64'(bus.BUSY_COUNT), 64'd0);
    check_eq("x0_stall", 64'(bus.STALL), 64'd0);

    // WAW on x7.
    bus.ISSUE_VALID = 1'b1; bus.ISSUE_RD = 5'd7;
    tick();
    #1;
    check_eq("x7_count", 64'(bus.BUSY_COUNT), 64'd1);
    check_eq("x7_waw_stall", 64'(bus.STALL), 64'd1);
    tick();
    check_eq("x7_waw_count", 64'(bus.BUSY_COUNT), 64'd1);

    // Busy x3/x9 (plus x7), B waiting behind A, then asynchronous reset.
    bus.ISSUE_RD = 5'd3;
    #1;
    check_eq("x3_issue_stall", 64'(bus.STALL), 64'd0);
    tick();
    bus.ISSUE_RD = 5'd9;
    tick();
    bus.ISSUE_VALID = 1'b0; bus.ISSUE_LONG = 1'b0;
    bus.RS1_ADDRESS = 5'd3;
    #1;
    check_eq("pre_rst_count", 64'(bus.BUSY_COUNT), 64'd3);
    check_eq("pre_rst_stall", 64'(bus.STALL), 64'd1);
    bus.A_VALID = 1'b1; bus.A_ADDRESS = 5'd4; bus.A_DATA = 32'h0000_0044;
    bus.B_VALID = 1'b1; bus.B_ADDRESS = 5'd3; bus.B_DATA = 32'h0000_0033;
    #1;
    check_eq("pre_rst_a_ready", 64'(bus.A_READY), 64'd1);
    check_eq("pre_rst_b_ready", 64'(bus.B_READY), 64'd0);
    push_wb(5'd4, 32'h0000_0044);
    tick();
    bus.A_DATA = 32'h0000_0045;
    #2 RST = 1'b1;
    #1;
    check_eq("async_rst_we", 64'(bus.RD_WRITE_EN), 64'd0);
    check_eq("async_rst_addr", 64'(bus.RD_ADDRESS), 64'd0);
    check_eq("async_rst_count", 64'(bus.BUSY_COUNT), 64'd0);
    check_eq("async_rst_stall", 64'(bus.STALL), 64'd0);
    bus.A_VALID = 1'b0; bus.B_VALID = 1'b0; bus.RS1_ADDRESS = '0;
    tick();
    RST = 1'b0;
    tick();
    check_eq("post_rst_count", 64'(bus.BUSY_COUNT), 64'd0);
    check_eq("leftover_queue", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
